// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern engine: rotate left/right, ping-pong and blink-all
// with a power-of-two programmable step period and a pause input.
module led_pattern_gen #(
  parameter int CLK_FREQ = 300_000_000,
  parameter int LED_NUM  = 8,
  parameter int STEP_HZ  = 4
) (
  input  logic               CLK_i,
  input  logic               RST_i,
  input  logic [1:0]         MODE_i,
  input  logic [2:0]         SPEED_i,
  input  logic               PAUSE_i,
  output logic [LED_NUM-1:0] LED_o,
  output logic               STEP_o
);

  localparam longint BASE_TICKS = longint'(CLK_FREQ) / longint'(STEP_HZ);
  localparam int     CNT_W      = $clog2(BASE_TICKS * 128);
  // One extra bit so BASE_TICKS<<7 is representable before subtracting one.
  localparam logic [CNT_W:0]       BASE_CNT = (CNT_W+1)'(BASE_TICKS);
  localparam logic [LED_NUM-1:0]   INIT_LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0]   INIT_MSB = INIT_LSB << (LED_NUM - 1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [1:0]         mode_q, mode_d;
  logic [2:0]         spd_q, spd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_t               dir_q, dir_d;
  logic [LED_NUM-1:0] led_d;
  logic               step_d;

  logic [CNT_W:0]       period, period_m1;
  logic                 tick;
  logic [2*LED_NUM-1:0] led_dbl;
  logic [LED_NUM-1:0]   rol, ror, pp_next, stepped;

  assign period    = BASE_CNT << spd_q;
  assign period_m1 = period - (CNT_W+1)'(1);
  assign tick      = !PAUSE_i && ({1'b0, cnt_q} == period_m1);

  // Doubling the vector turns both rotations into plain part-selects,
  // which also degenerate to "hold" when LED_NUM is 1.
  assign led_dbl = {LED_o, LED_o};
  assign rol     = led_dbl[LED_NUM-1 +: LED_NUM];
  assign ror     = led_dbl[1 +: LED_NUM];

  always_comb begin
    pp_next = LED_o;
    if (LED_NUM > 1)
      pp_next = (dir_q == DIR_UP) ? (LED_o << 1) : (LED_o >> 1);
    stepped = LED_o;
    case (mode_q)
      2'd0:    stepped = rol;
      2'd1:    stepped = ror;
      2'd2:    stepped = pp_next;
      default: stepped = ~LED_o;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    spd_d  = spd_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    led_d  = LED_o;
    step_d = 1'b0;
    if (MODE_i != mode_q) begin
      // A mode change restarts the pattern and swallows a coincident tick.
      mode_d = MODE_i;
      cnt_d  = '0;
      dir_d  = DIR_UP;
      case (MODE_i)
        2'd1:    led_d = INIT_MSB;
        2'd3:    led_d = '1;
        default: led_d = INIT_LSB;
      endcase
      if (tick)
        spd_d = SPEED_i;
    end else if (tick) begin
      cnt_d  = '0;
      spd_d  = SPEED_i;
      led_d  = stepped;
      step_d = 1'b1;
      if (mode_q == 2'd2 && LED_NUM > 1) begin
        if (pp_next[LED_NUM-1])
          dir_d = DIR_DOWN;
        else if (pp_next[0])
          dir_d = DIR_UP;
      end
    end else if (!PAUSE_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      mode_q <= 2'd0;
      spd_q  <= 3'd0;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      LED_o  <= INIT_LSB;
      STEP_o <= 1'b0;
    end else begin
      mode_q <= mode_d;
      spd_q  <= spd_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      LED_o  <= led_d;
      STEP_o <= step_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen with CLK_FREQ=16, STEP_HZ=4 (4-cycle base period), LED_NUM=4.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [2:0] speed;
  logic       pause;
  logic [3:0] led;
  logic       step;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];

  // reference state
  logic [3:0] m_led;
  logic [1:0] m_mode;
  logic [2:0] m_spd;
  int         m_cnt;
  logic       m_dir;   // 0 = up, 1 = down
  logic       m_step;

  led_pattern_gen #(.CLK_FREQ(16), .LED_NUM(4), .STEP_HZ(4)) dut (
    .CLK_i(clk), .RST_i(rst), .MODE_i(mode), .SPEED_i(speed),
    .PAUSE_i(pause), .LED_o(led), .STEP_o(step)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic tick;
    if (rst) begin
      m_led = 4'b0001; m_mode = 2'd0; m_spd = 3'd0; m_cnt = 0; m_dir = 1'b0; m_step = 1'b0;
    end else begin
      tick   = !pause && (m_cnt == (4 << m_spd) - 1);
      m_step = 1'b0;
      if (mode != m_mode) begin
        m_mode = mode;
        m_cnt  = 0;
        m_dir  = 1'b0;
        m_led  = (mode == 2'd1) ? 4'b1000 : (mode == 2'd3) ? 4'b1111 : 4'b0001;
        if (tick) m_spd = speed;
      end else if (tick) begin
        m_cnt  = 0;
        m_spd  = speed;
        m_step = 1'b1;
        case (m_mode)
          2'd0: m_led = {m_led[2:0], m_led[3]};
          2'd1: m_led = {m_led[0], m_led[3:1]};
          2'd2: begin
            if (!m_dir) begin
              m_led = {m_led[2:0], 1'b0};
              if (m_led[3]) m_dir = 1'b1;
            end else begin
              m_led = {1'b0, m_led[3:1]};
              if (m_led[0]) m_dir = 1'b0;
            end
          end
          default: m_led = ~m_led;
        endcase
      end else if (!pause) begin
        m_cnt++;
      end
    end
  endtask

  // driver: one clock with scoreboard push at the edge and pop away from it
  task automatic cycle();
    logic [4:0] e;
    @(posedge clk);
    model_update();
    exp_q.push_back({m_step, m_led});
    @(negedge clk);
    e = exp_q.pop_front();
    chk("scoreboard", {27'd0, step, led}, {27'd0, e});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_step(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      n++;
      if (step) return;
    end
    chk("step_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int steps;
    logic [3:0] pp_exp[7];
    pp_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    rst = 1'b1; mode = 2'd0; speed = 3'd0; pause = 1'b0;
    run(2);
    chk("reset_led", {28'd0, led}, 32'h1);
    chk("reset_step", {31'd0, step}, 32'd0);

    // rotate left, base period
    rst = 1'b0;
    wait_step(n);
    chk("first_step_gap", n, 4);
    chk("rotl_1", {28'd0, led}, 32'h2);
    steps = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (step) steps++;
    end
    chk("rotl_steps", steps, 4);
    chk("rotl_wrap", {28'd0, led}, 32'h1);

    // speed change mid-period
    run(2);
    speed = 3'd2;
    wait_step(n);
    chk("speed_cur_period", n, 2);
    wait_step(n);
    chk("speed_slow_period", n, 16);
    speed = 3'd0;
    wait_step(n);
    chk("speed_back_sampled", n, 16);
    wait_step(n);
    chk("speed_fast_again", n, 4);

    // pause at cnt=2
    run(2);
    pause = 1'b1;
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (step) steps++;
    end
    chk("pause_no_step", steps, 0);
    pause = 1'b0;
    wait_step(n);
    chk("pause_resume_gap", n, 2);

    // mode 0 -> 3 on the tick cycle
    run(3);
    mode = 2'd3;
    cycle();
    chk("blink_init", {28'd0, led}, 32'hF);
    chk("blink_init_nostep", {31'd0, step}, 32'd0);
    wait_step(n);
    chk("blink_gap1", n, 4);
    chk("blink_off", {28'd0, led}, 32'h0);
    wait_step(n);
    chk("blink_gap2", n, 4);
    chk("blink_on", {28'd0, led}, 32'hF);

    // reset mid-run with MODE_i held at 3
    run(2);
    rst = 1'b1;
    cycle();
    chk("midrun_reset_led", {28'd0, led}, 32'h1);
    rst = 1'b0;
    cycle();
    chk("post_reset_mode3", {28'd0, led}, 32'hF);

    // ping-pong
    mode = 2'd2;
    cycle();
    chk("pp_init", {28'd0, led}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      wait_step(n);
      chk($sformatf("pp_step%0d", i), {28'd0, led}, {28'd0, pp_exp[i]});
    end

    // rotate right
    mode = 2'd1;
    cycle();
    chk("rotr_init", {28'd0, led}, 32'h8);
    wait_step(n);
    chk("rotr_1", {28'd0, led}, 32'h4);

    // random stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      speed = 3'($urandom_range(0, 1));
      pause = ($urandom_range(0, 3) == 0);
      cycle();
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
